led_scan_reader: RTL

- Read-side consumer of the 8x8 LED frame RAM (64 x 4-bit pixel levels).
- Sequentially fetches one row of pixel levels through the RAM read port (one-hot row/col address in, registered data out, 1-cycle latency).
- Drives the multiplexed LED matrix row select and PWM column drivers, giving 16 brightness levels per pixel.
- Publishes the current scan row and a frame-start pulse, so light-pen timing logic can correlate detections with the lit row.

---
 rtl/led_scan_reader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/led_scan_reader.sv
// led_scan_reader: fetches one 8-pixel row of 4-bit levels from the frame RAM,
// then blanks the matrix and PWM-drives that row; rows are scanned 0..7 forever.
// Ports: clk; rst_n (async, active low); en (scan enable, level-sensitive);
//   addr_row/addr_col (one-hot RAM read address, 0 when idle); led_data (RAM
//   data, 1-cycle latency); row_sel/col_drv (matrix drivers, active high);
//   scan_row (current row index); frame_start (pulse at first fetch of row 0).
module led_scan_reader #(
    parameter int unsigned PWM_DIV      = 1024,
    parameter int unsigned PWM_PERIODS  = 4,
    parameter int unsigned BLANK_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic [7:0] addr_row,
    output logic [7:0] addr_col,
    input  logic [3:0] led_data,
    output logic [7:0] row_sel,
    output logic [7:0] col_drv,
    output logic [2:0] scan_row,
    output logic       frame_start
);

    typedef enum logic [1:0] {IDLE, FETCH, BLANK, SHOW} state_t;

    localparam logic [15:0] DIV_LAST   = 16'(PWM_DIV - 1);
    localparam logic [7:0]  PER_LAST   = 8'(PWM_PERIODS - 1);
    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);

    state_t          state;
    logic [3:0]      fidx;
    logic [15:0]     blank_cnt;
    logic [15:0]     div_cnt;
    logic [3:0]      pwm_cnt;
    logic [7:0]      per_cnt;
    logic [7:0][3:0] pix;

    logic [2:0] row_next;
    logic [3:0] pwm_next;

    assign row_next = scan_row + 3'd1;
    assign pwm_next = (pwm_cnt == 4'd14) ? 4'd0 : pwm_cnt + 4'd1;

    function automatic logic [7:0] onehot(input logic [2:0] i);
        return 8'd1 << i;
    endfunction

    // Column c is lit while its level exceeds the PWM step, so level 0 never
    // lights and level 15 always does (steps only run 0..14).
    function automatic logic [7:0] mask_at(input logic [7:0][3:0] p,
                                           input logic [3:0] lvl);
        logic [7:0] m;
        m = '0;
        for (int c = 0; c < 8; c++) m[c] = (p[c] > lvl);
        return m;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fidx        <= '0;
            blank_cnt   <= '0;
            div_cnt     <= '0;
            pwm_cnt     <= '0;
            per_cnt     <= '0;
            pix         <= '0;
            addr_row    <= '0;
            addr_col    <= '0;
            row_sel     <= '0;
            col_drv     <= '0;
            scan_row    <= '0;
            frame_start <= 1'b0;
        end else if (state != IDLE && !en) begin
            state       <= IDLE;
            fidx        <= '0;
            blank_cnt   <= '0;
            div_cnt     <= '0;
            pwm_cnt     <= '0;
            per_cnt     <= '0;
            addr_row    <= '0;
            addr_col    <= '0;
            row_sel     <= '0;
            col_drv     <= '0;
            scan_row    <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en) begin
                        state       <= FETCH;
                        fidx        <= '0;
                        scan_row    <= '0;
                        addr_row    <= onehot(3'd0);
                        addr_col    <= onehot(3'd0);
                        frame_start <= 1'b1;
                    end
                end
                FETCH: begin
                    // Data for column fidx-1 arrives one cycle after its address.
                    if (fidx != 4'd0) pix[3'(fidx - 4'd1)] <= led_data;
                    if (fidx == 4'd8) begin
                        state     <= BLANK;
                        blank_cnt <= '0;
                    end else begin
                        fidx <= fidx + 4'd1;
                        if (fidx == 4'd7) begin
                            addr_row <= '0;
                            addr_col <= '0;
                        end else begin
                            addr_col <= onehot(3'(fidx + 4'd1));
                        end
                    end
                end
                BLANK: begin
                    if (blank_cnt == BLANK_LAST) begin
                        state   <= SHOW;
                        div_cnt <= '0;
                        pwm_cnt <= '0;
                        per_cnt <= '0;
                        row_sel <= onehot(scan_row);
                        col_drv <= mask_at(pix, 4'd0);
                    end else begin
                        blank_cnt <= blank_cnt + 16'd1;
                    end
                end
                SHOW: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 16'd1;
                    end else begin
                        div_cnt <= '0;
                        if (pwm_cnt == 4'd14 && per_cnt == PER_LAST) begin
                            state       <= FETCH;
                            fidx        <= '0;
                            row_sel     <= '0;
                            col_drv     <= '0;
                            scan_row    <= row_next;
                            addr_row    <= onehot(row_next);
                            addr_col    <= onehot(3'd0);
                            frame_start <= (row_next == 3'd0);
                        end else begin
                            pwm_cnt <= pwm_next;
                            if (pwm_cnt == 4'd14) per_cnt <= per_cnt + 8'd1;
                            col_drv <= mask_at(pix, pwm_next);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
